// File: rtl/rect_plotter.sv
// Rectangle rasteriser for the VGA adapter pixel-write port: filled box, outline box
// or full-screen clear, one pixel per clock, clipped to the screen.
`timescale 1ns/1ps
module rect_plotter #(
    parameter int unsigned X_SCREEN_PIXELS = 160,
    parameter int unsigned Y_SCREEN_PIXELS = 120,
    parameter int unsigned X_W             = 8,
    parameter int unsigned Y_W             = 7,
    parameter int unsigned COLOUR_W        = 3
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iStart,
    input  logic [1:0]          iMode,
    input  logic [X_W-1:0]      iX,
    input  logic [Y_W-1:0]      iY,
    input  logic [X_W-1:0]      iW,
    input  logic [Y_W-1:0]      iH,
    input  logic [COLOUR_W-1:0] iColour,
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    localparam logic [X_W:0] X_SCR = (X_W+1)'(X_SCREEN_PIXELS);
    localparam logic [Y_W:0] Y_SCR = (Y_W+1)'(Y_SCREEN_PIXELS);

    state_t state_q, state_d;

    logic [X_W:0] x_ext, w_ext, x_rem, w_clip;
    logic [Y_W:0] y_ext, h_ext, y_rem, h_clip;
    logic         is_clear, empty;

    logic                outline_q;
    logic [COLOUR_W-1:0] colour_q;
    logic [X_W-1:0]      x0_q, col_q;
    logic [Y_W-1:0]      y0_q, row_q;
    logic [X_W:0]        w_last_q;
    logic [Y_W:0]        h_last_q;
    logic                last_col, last_row;

    // Clipped size, one bit wider than the fields so the subtraction cannot wrap
    always_comb begin
        is_clear = (iMode == 2'b10);
        x_ext    = {1'b0, iX};
        y_ext    = {1'b0, iY};
        w_ext    = {1'b0, iW};
        h_ext    = {1'b0, iH};
        x_rem    = (x_ext < X_SCR) ? (X_SCR - x_ext) : '0;
        y_rem    = (y_ext < Y_SCR) ? (Y_SCR - y_ext) : '0;
        w_clip   = (w_ext < x_rem) ? w_ext : x_rem;
        h_clip   = (h_ext < y_rem) ? h_ext : y_rem;
        if (is_clear) begin
            w_clip = X_SCR;
            h_clip = Y_SCR;
        end
        empty = (w_clip == '0) || (h_clip == '0);
    end

    assign last_col = ({1'b0, col_q} == w_last_q);
    assign last_row = ({1'b0, row_q} == h_last_q);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        oPlot   = 1'b0;
        oBusy   = 1'b0;
        oDone   = 1'b0;
        case (state_q)
            IDLE: begin
                if (iStart) state_d = empty ? DONE : DRAW;
            end
            DRAW: begin
                oBusy = 1'b1;
                oPlot = !outline_q || (col_q == '0) || (row_q == '0) || last_col || last_row;
                if (last_col && last_row) state_d = DONE;
            end
            DONE: begin
                oBusy   = 1'b1;
                oDone   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Nothing is latched for an empty request and the counters park on the last
    // pixel, so the pixel outputs keep their previous values outside DRAW.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            outline_q <= 1'b0;
            colour_q  <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            w_last_q  <= '0;
            h_last_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (iStart && !empty) begin
                        outline_q <= (iMode == 2'b01);
                        colour_q  <= iColour;
                        x0_q      <= is_clear ? '0 : iX;
                        y0_q      <= is_clear ? '0 : iY;
                        w_last_q  <= w_clip - 1'b1;
                        h_last_q  <= h_clip - 1'b1;
                        col_q     <= '0;
                        row_q     <= '0;
                    end
                end
                DRAW: begin
                    if (!last_col) begin
                        col_q <= col_q + 1'b1;
                    end else if (!last_row) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oX      = x0_q + col_q;
    assign oY      = y0_q + row_q;
    assign oColour = colour_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Self-checking bench for rect_plotter: directed and random rectangles compared
// cycle by cycle against a pixel-list reference model.
`timescale 1ns/1ps
module tb_rect_plotter;

    localparam int XS = 160;
    localparam int YS = 120;

    logic       iClock = 1'b0;
    logic       iResetn = 1'b0;
    logic       iStart = 1'b0;
    logic [1:0] iMode = '0;
    logic [7:0] iX = '0, iW = '0;
    logic [6:0] iY = '0, iH = '0;
    logic [2:0] iColour = '0;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot, oBusy, oDone;

    int n_tests = 0;
    int n_fail  = 0;
    int last_x = 0, last_y = 0, last_c = 0;

    rect_plotter #(
        .X_SCREEN_PIXELS(XS),
        .Y_SCREEN_PIXELS(YS),
        .X_W(8),
        .Y_W(7),
        .COLOUR_W(3)
    ) dut (
        .iClock(iClock),
        .iResetn(iResetn),
        .iStart(iStart),
        .iMode(iMode),
        .iX(iX),
        .iY(iY),
        .iW(iW),
        .iH(iH),
        .iColour(iColour),
        .oX(oX),
        .oY(oY),
        .oColour(oColour),
        .oPlot(oPlot),
        .oBusy(oBusy),
        .oDone(oDone)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input int busy);
        check({tag, " plot"}, int'(oPlot), 0);
        check({tag, " done"}, int'(oDone), 0);
        check({tag, " busy"}, int'(oBusy), busy);
        check({tag, " x"}, int'(oX), last_x);
        check({tag, " y"}, int'(oY), last_y);
        check({tag, " colour"}, int'(oColour), last_c);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after DONE.
    task automatic draw(input int mode, input int x, input int y, input int w, input int h,
                        input int c, input bit hold_start, input bit scramble);
        int x0, y0, wc, hc;
        bit plot_exp;
        iMode = 2'(mode); iX = 8'(x); iY = 7'(y); iW = 8'(w); iH = 7'(h); iColour = 3'(c);
        iStart = 1'b1;
        if (mode == 2) begin
            x0 = 0; y0 = 0; wc = XS; hc = YS;
        end else begin
            x0 = x; y0 = y;
            wc = (x >= XS) ? 0 : ((w < XS - x) ? w : XS - x);
            hc = (y >= YS) ? 0 : ((h < YS - y) ? h : YS - y);
        end
        @(negedge iClock);
        iStart = 1'b0;
        for (int r = 0; r < hc; r++) begin
            for (int k = 0; k < wc; k++) begin
                plot_exp = (mode != 1) || r == 0 || k == 0 || r == hc - 1 || k == wc - 1;
                check("draw plot", int'(oPlot), int'(plot_exp));
                check("draw x", int'(oX), x0 + k);
                check("draw y", int'(oY), y0 + r);
                check("draw colour", int'(oColour), c);
                check("draw busy", int'(oBusy), 1);
                check("draw done", int'(oDone), 0);
                if (scramble) begin
                    iStart = 1'($urandom); iMode = 2'($urandom); iX = 8'($urandom);
                    iY = 7'($urandom); iW = 8'($urandom); iH = 7'($urandom);
                    iColour = 3'($urandom);
                end
                @(negedge iClock);
            end
        end
        if (wc > 0 && hc > 0) begin
            last_x = x0 + wc - 1;
            last_y = y0 + hc - 1;
            last_c = c;
        end
        check("done pulse", int'(oDone), 1);
        check("done plot", int'(oPlot), 0);
        check("done busy", int'(oBusy), 1);
        check("done x", int'(oX), last_x);
        check("done y", int'(oY), last_y);
        check("done colour", int'(oColour), last_c);
        iStart = hold_start;
        @(negedge iClock);
        check_quiet("idle gap", 0);
    endtask

    task automatic reset_mid_draw();
        iMode = 2'b00; iX = 8'd30; iY = 7'd40; iW = 8'd4; iH = 7'd4; iColour = 3'd6;
        iStart = 1'b1;
        @(negedge iClock);
        iStart = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("pre-reset x", int'(oX), 30 + k % 4);
            check("pre-reset y", int'(oY), 40 + k / 4);
            check("pre-reset plot", int'(oPlot), 1);
            @(negedge iClock);
        end
        #2 iResetn = 1'b0;
        last_x = 0; last_y = 0; last_c = 0;
        #1 check_quiet("async reset", 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge iClock);
            check_quiet("in reset", 0);
        end
        iResetn = 1'b1;
        @(negedge iClock);
        check_quiet("after reset", 0);
        draw(0, 30, 40, 4, 4, 6, 1'b0, 1'b0);
    endtask

    initial begin
        #1 check_quiet("reset", 0);
        @(negedge iClock);
        @(negedge iClock);
        iResetn = 1'b1;
        @(negedge iClock);
        check_quiet("post reset idle", 0);

        draw(0, 10, 20, 4, 4, 5, 1'b0, 1'b0);
        draw(1, 0, 0, 3, 3, 2, 1'b0, 1'b0);
        draw(2, 50, 50, 3, 3, 0, 1'b0, 1'b0);
        draw(2, 90, 7, 0, 0, 7, 1'b0, 1'b0);
        draw(0, 158, 118, 4, 4, 3, 1'b0, 1'b0);
        draw(0, 10, 10, 0, 5, 1, 1'b0, 1'b0);
        draw(0, 200, 10, 4, 4, 1, 1'b0, 1'b0);
        draw(0, 10, 20, 4, 4, 5, 1'b0, 1'b1);
        draw(3, 5, 5, 2, 2, 4, 1'b1, 1'b0);
        draw(1, 7, 7, 3, 2, 1, 1'b0, 1'b0);
        draw(1, 150, 100, 20, 30, 6, 1'b0, 1'b0);

        reset_mid_draw();

        for (int i = 0; i < 40; i++) begin
            int m;
            m = int'($urandom_range(0, 2));
            if (m == 2) m = 3;
            draw(m, int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 12)), int'($urandom_range(0, 10)),
                 int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        end
        draw(1, 1, 1, 1, 1, 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
